// File: rtl/serial_boot_loader.sv
// UART (8N1) boot loader: receives a framed program image and writes 32-bit
// words into the instruction store through a single-cycle write port.
module serial_boot_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         MAX_WORDS    = 64,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_auto,
  input  logic        rst_n,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  // S_IDLE wait sync | S_COUNT word count | S_DATA payload | S_CHECK checksum | S_DONE/S_ERROR sticky result
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR} state_e;

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  widx_q, widx_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;

  // Until the line has idled high for one bit time after reset, the timer
  // measures that idle period and no start bit is accepted.
  always_comb begin
    rx_state_d   = rx_state_q;
    tmr_d        = tmr_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!armed_q) begin
          if (!rx_s2_q)          tmr_d = BIT_LOAD;
          else if (tmr_q == '0)  armed_d = 1'b1;
          else                   tmr_d = tmr_q - 1'b1;
        end else if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          tmr_d      = HALF_LOAD;
        end
      end
      RX_START: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (rx_s2_q) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          tmr_d      = BIT_LOAD;
          bit_idx_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          tmr_d     = BIT_LOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else begin
          byte_valid_d = rx_s2_q;
          frame_err_d  = !rx_s2_q;
          rx_state_d   = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    widx_d     = widx_q;
    bsel_d     = bsel_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (byte_valid_q && shift_q == SYNC_BYTE) begin
          state_d = S_COUNT;
          csum_d  = 8'h00;
          widx_d  = 8'h00;
          bsel_d  = 2'd0;
        end
      end
      S_COUNT: begin
        if (byte_valid_q) begin
          if (shift_q == 8'h00)                  state_d = S_CHECK;
          else if (int'(shift_q) > MAX_WORDS)    state_d = S_ERROR;
          else begin
            count_d = shift_q;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_valid_q) begin
          csum_d = csum_q ^ shift_q;
          asm_d  = {asm_q[15:0], shift_q};
          bsel_d = bsel_q + 1'b1;
          if (bsel_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_data_d = {asm_q, shift_q};
            mem_addr_d = 32'(widx_q);
            widx_d     = widx_q + 8'd1;
            if (widx_q + 8'd1 == count_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (byte_valid_q) state_d = (shift_q == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_err_q && busy) state_d = S_ERROR;
  end

  always_ff @(posedge clk_auto or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      tmr_q        <= BIT_LOAD;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= S_IDLE;
      count_q      <= 8'h00;
      widx_q       <= 8'h00;
      bsel_q       <= 2'd0;
      asm_q        <= 24'h0;
      csum_q       <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= 32'h0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      tmr_q        <= tmr_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      bsel_q       <= bsel_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_serial_boot_loader.sv
// Self-checking bench for serial_boot_loader: frames are built at byte level and
// the expected writes/status are derived from the frame contents.
module tb_serial_boot_loader;
  localparam int CPB  = 4;
  localparam int MAXW = 64;

  logic        clk_auto = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        mem_we;
  logic [31:0] mem_addr, mem_data;
  logic        busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  always #5 clk_auto = ~clk_auto;

  serial_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
    .clk_auto(clk_auto), .rst_n(rst_n), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .error(error));

  always @(negedge clk_auto) if (rst_n && mem_we) got_q.push_back({mem_addr, mem_data});

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_auto);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_auto);
    end
    rx = ~bad_stop;
    repeat (CPB) @(negedge clk_auto);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk_auto);
  endtask

  task automatic glitch();
    rx = 1'b0;
    @(negedge clk_auto);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_auto);
  endtask

  // Reference: every payload word lands at consecutive addresses from 0; the
  // trailer is the XOR of all payload bytes (inverted when corrupt is set).
  task automatic send_frame(input logic [31:0] words[$], input bit corrupt, input bit glitch_after_sync);
    logic [7:0] ck;
    ck = 8'h00;
    exp_q.delete();
    send_byte(8'hA5, 1'b0);
    if (glitch_after_sync) glitch();
    send_byte(8'(words.size()), 1'b0);
    foreach (words[i]) begin
      exp_q.push_back({32'(i), words[i]});
      for (int k = 3; k >= 0; k--) begin
        send_byte(words[i][8*k +: 8], 1'b0);
        ck = ck ^ words[i][8*k +: 8];
      end
    end
    send_byte(corrupt ? ~ck : ck, 1'b0);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_auto);
    n_tests++;
    if ({mem_we, mem_addr, mem_data, busy, done, error} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b err=%b expected all 0",
               mem_we, mem_addr, mem_data, busy, done, error);
    end
    rst_n = 1'b1;
    repeat (5 * CPB) @(negedge clk_auto);
  endtask

  task automatic test_single_word();
    logic [31:0] wq[$];
    wq = {32'h6800_0001};
    got_q.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL single_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_two_words();
    logic [31:0] wq[$];
    wq = {32'h3000_0005, 32'h7400_0000};
    got_q.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL two_count: got %0d expected 2", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL two_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] wq[$];
    wq = {32'h6800_0001};
    got_q.delete();
    send_frame(wq, 1'b1, 1'b0);
    n_tests++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL badck_count: got %0d expected 1", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badck_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b010) begin n_fail++; $display("FAIL badck_status: got d/e/b=%b%b%b expected 010", done, error, busy); end
  endtask

  task automatic test_bad_count();
    logic [31:0] wq[$];
    got_q.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h41, 1'b0);
    n_tests++;
    if (got_q.size() != 0 || {done, error, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL badcount: got writes=%0d d/e/b=%b%b%b expected 0 and 010", got_q.size(), done, error, busy);
    end
    wq.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != 0 || {done, error, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_words: got writes=%0d d/e/b=%b%b%b expected 0 and 100", got_q.size(), done, error, busy);
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] wq[$];
    got_q.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    n_tests++;
    if (got_q.size() != 0 || {done, error, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL frame_err: got writes=%0d d/e/b=%b%b%b expected 0 and 010", got_q.size(), done, error, busy);
    end
    wq = {$urandom(), $urandom()};
    got_q.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL after_ferr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL after_ferr_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL after_ferr_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_glitch_garbage();
    logic [31:0] wq[$];
    got_q.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    glitch();
    n_tests++;
    if (got_q.size() != 0 || {done, error, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL garbage_ignored: got writes=%0d d/e/b=%b%b%b expected 0 and 100", got_q.size(), done, error, busy);
    end
    wq = {$urandom(), $urandom(), $urandom()};
    send_frame(wq, 1'b0, 1'b1);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL glitch_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_max_words();
    logic [31:0] wq[$];
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom());
    got_q.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != MAXW) begin n_fail++; $display("FAIL max_count: got %0d expected %0d", got_q.size(), MAXW); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL max_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL max_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] w0;
    logic [31:0] wq[$];
    w0 = $urandom();
    got_q.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int k = 3; k >= 0; k--) send_byte(w0[8*k +: 8], 1'b0);
    send_byte(8'h5C, 1'b0);
    send_byte(8'hC3, 1'b0);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== {32'h0, w0} || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_frame: got writes=%0d busy=%b expected 1 write of %h and busy=1", got_q.size(), busy, w0);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_data, busy, done, error} !== 68'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got we=%b addr=%h data=%h busy=%b done=%b err=%b expected all 0",
               mem_we, mem_addr, mem_data, busy, done, error);
    end
    repeat (3) @(negedge clk_auto);
    rst_n = 1'b1;
    repeat (5 * CPB) @(negedge clk_auto);
    wq = {$urandom(), $urandom()};
    got_q.delete();
    send_frame(wq, 1'b0, 1'b0);
    n_tests++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL fresh_count: got %0d expected 2", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fresh_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL fresh_status: got d/e/b=%b%b%b expected 100", done, error, busy); end
  endtask

  task automatic test_random();
    logic [31:0] wq[$];
    logic [7:0]  g, n;
    bit          corrupt;
    logic [2:0]  exp_st;
    for (int it = 0; it < 10; it++) begin
      got_q.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b0);
      end
      if ($urandom_range(0, 5) == 0) begin
        n = 8'($urandom_range(MAXW + 1, 100));
        exp_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(n, 1'b0);
        exp_st = 3'b010;
      end else begin
        wq.delete();
        for (int j = 0; j < int'($urandom_range(0, 4)); j++) wq.push_back($urandom());
        corrupt = ($urandom_range(0, 2) == 0);
        send_frame(wq, corrupt, 1'b0);
        exp_st = corrupt ? 3'b010 : 3'b100;
      end
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_write[%0d]: got %h expected %h", it, i, got_q[i], exp_q[i]); end
      end
      n_tests++;
      if ({done, error, busy} !== exp_st) begin n_fail++; $display("FAIL rand%0d_status: got d/e/b=%b%b%b expected %b", it, done, error, busy, exp_st); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_checksum();
    test_bad_count();
    test_frame_err();
    test_glitch_garbage();
    test_max_words();
    test_midframe_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_boot_loader.md
Name: serial_boot_loader

Overview:
- Writer side of the instruction ROM path: receives a program image over a UART line and writes 32-bit instruction words into the instruction store, which the core later fetches word-by-word by address.
- Contains a UART receiver (8N1), byte-to-word assembler, framing/checksum FSM and a single-cycle memory write port.
- Sits between the board serial pin and the write port of the instruction memory; the core is held off while busy is high.

Parameters:
- CLKS_PER_BIT, 434, clk_auto cycles per UART bit (50 MHz / 115200); minimum legal value 4.
- MAX_WORDS, 64, instruction store depth in words; the loader never writes an address >= MAX_WORDS.
- SYNC_BYTE, 8'hA5, session start marker.

Ports:
- clk_auto  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk_auto.
- mem_we  out  1  one-cycle write strobe to the instruction store.
- mem_addr  out  32  word address of the write, zero-extended from a 6-bit word index.
- mem_data  out  32  instruction word to be written.
- busy  out  1  high from SYNC_BYTE acceptance until done or error.
- done  out  1  sticky: image loaded and checksum matched.
- error  out  1  sticky: framing error, bad count or checksum mismatch.

Behaviour:
- Reset (async, rst_n=0): mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, FSM=IDLE, rx synchroniser preset to 1, checksum=0, word index=0.
- rx passes through a 2-FF synchroniser before use.
- UART RX: falling edge on synced rx starts a bit; re-sampled at CLKS_PER_BIT/2. If it is high, this is a glitch: return to idle, no byte. Sample 8 data bits LSB first, one every CLKS_PER_BIT, then the stop bit. A stop bit of 1 raises byte_valid for 1 cycle on the cycle after the stop sample. A stop bit of 0 raises frame_err for 1 cycle instead; no byte.
- Frame format: SYNC_BYTE, N (word count), N*4 payload bytes (big-endian, MSB first per word), C. C is the XOR of all payload bytes.
- FSM states:
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> COUNT, busy=1, done=0, error=0, checksum=0, index=0.
  - COUNT: if N=0, go to CHECK. If N>MAX_WORDS, go to ERROR. Otherwise latch N and go to DATA.
  - DATA: shift each byte into a 32-bit assembly register and XOR it into the checksum. On the 4th byte, in the cycle after that byte_valid: mem_we=1 for exactly 1 cycle, mem_data=assembled word, mem_addr=index; index then increments. After the Nth word -> CHECK.
  - CHECK: the next byte is compared with the checksum. Equal -> DONE; different -> ERROR.
  - DONE: done=1, busy=0.
  - ERROR: error=1, busy=0.
  - From DONE or ERROR, a SYNC_BYTE starts a new session as from IDLE; all other bytes are ignored.
- frame_err while busy -> ERROR immediately; the partially assembled word is discarded, and words already written stay in memory. frame_err in IDLE/DONE/ERROR is ignored.
- mem_addr and mem_data hold their last values when mem_we=0.
- No timeout: an incomplete frame leaves busy=1 indefinitely until reset.
- A reset in mid-frame aborts the session with no further writes. The receiver resynchronises on the next falling edge after rx has been high for at least 1 bit time.

Test Plan (CLKS_PER_BIT=4, MAX_WORDS=64):
- Send A5, 01, 68, 00, 00, 01, C -> one mem_we pulse with addr=0, data=32'h68000001. C=0x68^0x00^0x00^0x01=0x69, so checksum matches and done=1, busy=0, error=0.
- Send A5, 02, then words 0x30000005 and 0x74000000, then correct C=0x41 -> writes at addr 0 and 1 with those data values, then done=1.
- Same frame as the first scenario but C=0x00 -> the write at addr 0 still occurs, then error=1, done=0.
- Send A5, 41 (65 > MAX_WORDS) -> error=1 with no mem_we pulse. A following A5, 00, 00 clears error and sets done=1.
- Drive the stop bit low on the second payload byte -> error=1, no mem_we; the next valid frame is accepted normally.
- Garbage bytes 00, FF, 12 before A5, plus a 1-cycle low glitch on rx in IDLE -> no bytes decoded from the glitch, garbage ignored, and the following valid frame loads correctly.
- Assert rst_n=0 mid-payload -> all outputs 0 at once, then a fresh frame loads starting at addr 0.
